// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched
// Description : SHA-256 message-schedule sequencer. It loads one 512-bit block
//               as 16 serial 32-bit words, then streams W[0]..W[ROUNDS-1] to
//               the compression rounds, one word per handshake. Words W[16+]
//               are expanded in place in a 16-entry circular buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROUNDS    : schedule words emitted per block (16..64)
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   in_valid  : upstream word valid
//   in_ready  : block accepts an input word (IDLE / LOAD)
//   in_word   : message word, word 0 first
//   w_valid   : schedule word valid (registered)
//   w_ready   : downstream accepts the schedule word
//   w_word    : schedule word W[w_idx] (registered)
//   w_idx     : index t of w_word (registered)
//   w_last    : w_valid && w_idx == ROUNDS-1 (registered)
//   busy      : high in LOAD or EMIT (registered)
// ============================================================================
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_word,
    output logic [5:0]  w_idx,
    output logic        w_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_IDX = 6'(ROUNDS - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_buf [16];

    logic        w_in_acc;
    logic        w_out_hs;
    logic [5:0]  w_t_next;
    logic        w_t_next_exp;
    logic [3:0]  w_p;
    logic [3:0]  w_p_m2;
    logic [3:0]  w_p_m7;
    logic [3:0]  w_p_m15;
    logic [31:0] w_exp;
    logic [31:0] w_next_word;

    function automatic logic [31:0] f_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_ready = (r_state != ST_EMIT);
    assign w_in_acc = in_valid && in_ready;
    assign w_out_hs = w_valid && w_ready;

    // The word computed at a handshake is the one presented next (t+1).
    // 4-bit pointer arithmetic gives the modulo-16 buffer indexing for free;
    // buf[t+1 mod 16] still holds W[t-15] when it is read here.
    assign w_t_next     = w_idx + 6'd1;
    assign w_t_next_exp = (w_t_next[5:4] != 2'b00);
    assign w_p          = w_t_next[3:0];
    assign w_p_m2       = w_p - 4'd2;
    assign w_p_m7       = w_p - 4'd7;
    assign w_p_m15      = w_p - 4'd15;

    assign w_exp = f_sig1(r_buf[w_p_m2]) + r_buf[w_p_m7]
                 + f_sig0(r_buf[w_p_m15]) + r_buf[w_p];

    assign w_next_word = w_t_next_exp ? w_exp : r_buf[w_p];

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (w_in_acc) begin
            r_buf[r_cnt] <= in_word;
        end else if (w_out_hs && !w_last && w_t_next_exp) begin
            r_buf[w_p] <= w_exp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            w_word  <= 32'd0;
            w_idx   <= 6'd0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_in_acc) begin
                        // Wraps back to 0 on the 16th word, ready for the next block.
                        r_cnt <= r_cnt + 4'd1;
                        busy  <= 1'b1;
                        if (r_cnt == 4'd15) begin
                            // W[0] was stored on the first accept, long before now.
                            r_state <= ST_EMIT;
                            w_valid <= 1'b1;
                            w_word  <= r_buf[0];
                            w_idx   <= 6'd0;
                            w_last  <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_EMIT: begin
                    if (w_out_hs) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            w_valid <= 1'b0;
                            w_last  <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            w_idx  <= w_t_next;
                            w_word <= w_next_word;
                            w_last <= (w_t_next == c_LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_sched
// Description : Self-checking bench for sha256_msg_sched. Three instances
//               (ROUNDS = 64, 16, 20) run from one clock; expected schedule
//               words come from an independent 64-entry reference model and
//               are queued per instance as each block finishes loading.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_sched;

    typedef logic [38:0] ent_t;               // {word, idx, last}
    typedef struct {
        int          idx;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_s [3];
    logic        in_ready_s [3];
    logic [31:0] in_word_s  [3];
    logic        w_valid_s  [3];
    logic        w_ready_s  [3];
    logic [31:0] w_word_s   [3];
    logic [5:0]  w_idx_s    [3];
    logic        w_last_s   [3];
    logic        busy_s     [3];

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    ent_t        exp_q [3][$];
    ent_t        mon_e;
    logic [31:0] cap [3][64];
    logic [31:0] blk [16];
    vec_t        vt  [6];

    int          val_cnt [3];
    int          hs_cnt [3];
    int          first_valid_cyc [3];
    int          last_hs_cyc [3];
    int          stall16_cnt [3];
    int          stall_left [3];
    bit          bp_mode [3];
    bit          stall_done [3];
    bit          have_prev [3];
    bit          prev_valid [3];
    logic [39:0] prev_out [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int R = (d == 0) ? 64 : ((d == 1) ? 16 : 20);
        sha256_msg_sched #(.ROUNDS(R)) u_dut (
            .clk      (clk),
            .rst      (rst_n),
            .in_valid (in_valid_s[d]),
            .in_ready (in_ready_s[d]),
            .in_word  (in_word_s[d]),
            .w_valid  (w_valid_s[d]),
            .w_ready  (w_ready_s[d]),
            .w_word   (w_word_s[d]),
            .w_idx    (w_idx_s[d]),
            .w_last   (w_last_s[d]),
            .busy     (busy_s[d])
        );
    end

    function automatic int rounds_of(input int d);
        return (d == 0) ? 64 : ((d == 1) ? 16 : 20);
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name, input int act, input int exp);
        checks++;
        failures++;
        $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, "_in_ready"}, in_ready_s[d], 1'b1);
        chk({tag, "_w_valid"},  w_valid_s[d],  1'b0);
        chk({tag, "_w_last"},   w_last_s[d],   1'b0);
        chk({tag, "_busy"},     busy_s[d],     1'b0);
        chk({tag, "_w_word"},   w_word_s[d],   32'd0);
        chk({tag, "_w_idx"},    w_idx_s[d],    6'd0);
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    // Loads nwords words of blk; a complete block queues its reference schedule.
    // Called and returns at posedge+1.
    task automatic load_block(input int d, input bit gaps, input int nwords,
                              output int first_acc, output int last_acc);
        logic [31:0] gw [64];
        int          guard;
        int          r;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                in_valid_s[d] = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid_s[d] = 1'b1;
            in_word_s[d]  = blk[i];
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!in_ready_s[d] && guard < 200);
            if (!in_ready_s[d]) begin
                fail_note("load_accept_timeout", guard, 200);
                in_valid_s[d] = 1'b0;
                return;
            end
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk);
            #1;
        end
        in_valid_s[d] = 1'b0;
        if (nwords == 16) begin
            r = rounds_of(d);
            for (int t = 0; t < 64; t++) begin
                if (t < 16) gw[t] = blk[t];
                else gw[t] = ref_s1(gw[t-2]) + gw[t-7] + ref_s0(gw[t-15]) + gw[t-16];
            end
            for (int t = 0; t < r; t++) begin
                exp_q[d].push_back({gw[t], 6'(t), (t == r - 1)});
            end
        end
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n = 0;
        while (n < budget && (exp_q[d].size() != 0 || w_valid_s[d])) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[d].size() != 0 || w_valid_s[d])
            fail_note("drain_timeout_words_left", exp_q[d].size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: always high, or pseudo-random with a forced
    // 5-cycle stall the first time t=16 is presented.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            if (!bp_mode[d]) begin
                w_ready_s[d] = 1'b1;
            end else if (stall_left[d] > 0) begin
                w_ready_s[d] = 1'b0;
                stall_left[d]--;
            end else if (!stall_done[d] && w_valid_s[d] && w_idx_s[d] == 6'd16) begin
                w_ready_s[d]  = 1'b0;
                stall_left[d] = 4;
                stall_done[d] = 1'b1;
            end else begin
                w_ready_s[d] = ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                have_prev[d]  = 1'b0;
                prev_valid[d] = 1'b0;
            end else begin
                if (have_prev[d])
                    chk($sformatf("hold_d%0d_t%0d", d, prev_out[d][6:1]),
                        {w_valid_s[d], w_word_s[d], w_idx_s[d], w_last_s[d]}, prev_out[d]);
                have_prev[d] = w_valid_s[d] && !w_ready_s[d];
                prev_out[d]  = {w_valid_s[d], w_word_s[d], w_idx_s[d], w_last_s[d]};
                if (w_valid_s[d]) begin
                    val_cnt[d]++;
                    chk($sformatf("in_ready_emit_d%0d", d), in_ready_s[d], 1'b0);
                    if (!prev_valid[d]) first_valid_cyc[d] = cyc;
                    if (!w_ready_s[d] && w_idx_s[d] == 6'd16) begin
                        stall16_cnt[d]++;
                        chk("stall16_word", w_word_s[d], 32'h61626380);
                    end
                end
                prev_valid[d] = w_valid_s[d];
                if (w_valid_s[d] && w_ready_s[d]) begin
                    hs_cnt[d]++;
                    cap[d][w_idx_s[d]] = w_word_s[d];
                    if (w_last_s[d]) last_hs_cyc[d] = cyc;
                    if (exp_q[d].size() == 0) begin
                        fail_note($sformatf("unexpected_word_d%0d_idx", d), int'(w_idx_s[d]), -1);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        chk($sformatf("word_d%0d_t%0d", d, mon_e[6:1]), w_word_s[d], mon_e[38:7]);
                        chk($sformatf("idx_d%0d", d), w_idx_s[d], mon_e[6:1]);
                        chk($sformatf("last_d%0d_t%0d", d, mon_e[6:1]), w_last_s[d], mon_e[0]);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fa, la, fa2, la2, v0, h0, guard;

        vt[0] = '{0,  32'h61626380};
        vt[1] = '{15, 32'h00000018};
        vt[2] = '{16, 32'h61626380};
        vt[3] = '{17, 32'h000F0000};
        vt[4] = '{18, 32'h7DA86405};
        vt[5] = '{19, 32'h600003C6};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid_s[d] = 1'b0;
            in_word_s[d]  = 32'h0;
            w_ready_s[d]  = 1'b1;
            bp_mode[d]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_reset(d, $sformatf("por_d%0d", d));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc" block, w_ready held high.
        set_abc();
        for (int i = 0; i < 64; i++) cap[0][i] = 32'hDEADBEEF;
        v0 = val_cnt[0];
        h0 = hs_cnt[0];
        load_block(0, 1'b0, 16, fa, la);
        wait_drain(0, 400);
        chk("abc_valid_cycles", val_cnt[0] - v0, 64);
        chk("abc_word_count", hs_cnt[0] - h0, 64);
        chk("abc_emit_latency", first_valid_cyc[0], la + 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("abc_W%0d", vt[i].idx), cap[0][vt[i].idx], vt[i].exp);

        // Bursty load with random back-pressure and a 5-cycle stall at t=16.
        bp_mode[0]     = 1'b1;
        stall_done[0]  = 1'b0;
        stall16_cnt[0] = 0;
        h0 = hs_cnt[0];
        load_block(0, 1'b1, 16, fa, la);
        wait_drain(0, 1000);
        bp_mode[0] = 1'b0;
        chk("bursty_emit_latency", first_valid_cyc[0], la + 1);
        chk("stall16_at_least_5", (stall16_cnt[0] >= 5), 1'b1);
        chk("bp_word_count", hs_cnt[0] - h0, 64);

        // Back-to-back: second block (all ones) presented continuously.
        set_abc();
        load_block(0, 1'b0, 16, fa, la);
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        load_block(0, 1'b0, 16, fa2, la2);
        chk("b2b_turnaround", fa2, last_hs_cyc[0] + 1);
        wait_drain(0, 400);

        // Reset in LOAD after 9 words.
        set_abc();
        load_block(0, 1'b0, 9, fa, la);
        chk("load9_busy", busy_s[0], 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_reset(0, "rst_load");
        exp_q[0].delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in EMIT at t=40, then a fresh block.
        load_block(0, 1'b0, 16, fa, la);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(w_valid_s[0] && w_idx_s[0] == 6'd40) && guard < 200);
        chk("emit40_reached", w_valid_s[0] && w_idx_s[0] == 6'd40, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_reset(0, "rst_emit");
        exp_q[0].delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        v0 = val_cnt[0];
        repeat (10) @(negedge clk);
        chk("no_valid_after_rst", val_cnt[0] - v0, 0);
        @(posedge clk);
        #1;
        h0 = hs_cnt[0];
        load_block(0, 1'b0, 16, fa, la);
        wait_drain(0, 400);
        chk("post_rst_word_count", hs_cnt[0] - h0, 64);
        chk("post_rst_W19", cap[0][19], 32'h600003C6);

        // ROUNDS=16 and ROUNDS=20 instances.
        set_abc();
        cap[1][15] = 32'hDEADBEEF;
        h0 = hs_cnt[1];
        load_block(1, 1'b0, 16, fa, la);
        wait_drain(1, 200);
        chk("r16_word_count", hs_cnt[1] - h0, 16);
        chk("r16_W15", cap[1][15], 32'h00000018);
        chk("r16_last_idx", w_idx_s[1], 6'd15);

        cap[2][19] = 32'hDEADBEEF;
        h0 = hs_cnt[2];
        load_block(2, 1'b0, 16, fa, la);
        wait_drain(2, 200);
        chk("r20_word_count", hs_cnt[2] - h0, 20);
        chk("r20_W19", cap[2][19], 32'h600003C6);
        chk("r20_last_idx", w_idx_s[2], 6'd19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
